// File: rtl/reg_trace_rules_if.sv
// Front-end register bus between the USB register front end and the
// trace rule register block. The master drives address, strobes and
// write data; the slave returns the registered read byte.
interface reg_trace_rules_if #(
    parameter int pADDR_WIDTH   = 21,
    parameter int pBYTECNT_SIZE = 7
);
    logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address;
    logic [pBYTECNT_SIZE-1:0]             reg_bytecnt;
    logic [7:0]                           write_data;
    logic [7:0]                           read_data;
    logic                                 reg_read;
    logic                                 reg_write;
    logic                                 reg_addrvalid;

    modport master (
        output reg_address, reg_bytecnt, write_data,
        output reg_read, reg_write, reg_addrvalid,
        input  read_data
    );

    modport slave (
        input  reg_address, reg_bytecnt, write_data,
        input  reg_read, reg_write, reg_addrvalid,
        output read_data
    );
endinterface

// File: rtl/reg_trace_rules.sv
// Trace trigger register block: pMATCH_RULES staged pattern/mask rules with
// atomic commit, saturating per-rule hit counters, and a shared snapshot that
// keeps multi-byte status reads coherent across the byte-by-byte access.
module reg_trace_rules #(
    parameter int pADDR_WIDTH   = 21,
    parameter int pBYTECNT_SIZE = 7,
    parameter int pBUFFER_SIZE  = 64,
    parameter int pMATCH_RULES  = 8,
    parameter int pCOUNT_WIDTH  = 16
) (
    input  logic                                 usb_clk,
    input  logic                                 reset_i,
    reg_trace_rules_if.slave                     bus,
    input  logic [pMATCH_RULES-1:0]              I_matching_pattern,
    input  logic [pBUFFER_SIZE-1:0]              I_matching_buffer,
    input  logic [pBUFFER_SIZE-1:0]              I_last_blurb,
    input  logic                                 I_synchronized,
    input  logic [pMATCH_RULES-1:0]              I_match_hit,
    output logic [4:0]                           O_clksettings,
    output logic [pMATCH_RULES-1:0]              O_pattern_enable,
    output logic                                 O_trace_reset_sync,
    output logic                                 O_trig_toggle,
    output logic [2:0]                           O_trace_width,
    output logic [pMATCH_RULES*pBUFFER_SIZE-1:0] O_trace_pattern,
    output logic [pMATCH_RULES*pBUFFER_SIZE-1:0] O_trace_mask,
    output logic                                 O_commit
);
    localparam int AW        = pADDR_WIDTH - pBYTECNT_SIZE;
    localparam int EN_BYTES  = (pMATCH_RULES + 7) / 8;
    localparam int BUF_BYTES = pBUFFER_SIZE / 8;
    localparam int CNT_BYTES = pCOUNT_WIDTH / 8;
    // Widest readable register; also the width of the shared snapshot.
    localparam int VW = (pBUFFER_SIZE > pCOUNT_WIDTH)
                        ? ((pBUFFER_SIZE > 16) ? pBUFFER_SIZE : 16)
                        : ((pCOUNT_WIDTH > 16) ? pCOUNT_WIDTH : 16);
    localparam int VB = VW / 8;
    localparam logic [4:0] NRULES = 5'(pMATCH_RULES);

    typedef enum logic [3:0] {
        K_NONE, K_REV, K_ENABLE, K_WIDTH, K_TOGGLE, K_COMMIT, K_MPAT, K_MBUF,
        K_SYNC, K_BLURB, K_CLK, K_RSYNC, K_PAT, K_MASK, K_COUNT
    } reg_kind_e;

    logic [AW-1:0]            addr;
    logic [3:0]               rule;
    logic [pBYTECNT_SIZE-1:0] bytecnt;
    logic                     byte0;
    logic                     rule_ok;
    logic                     wr;
    logic                     rd;
    reg_kind_e                kind;

    logic [pBUFFER_SIZE-1:0]  stage_pat  [pMATCH_RULES];
    logic [pBUFFER_SIZE-1:0]  stage_mask [pMATCH_RULES];
    logic [pBUFFER_SIZE-1:0]  act_pat    [pMATCH_RULES];
    logic [pBUFFER_SIZE-1:0]  act_mask   [pMATCH_RULES];
    logic [pCOUNT_WIDTH-1:0]  cnt        [pMATCH_RULES];
    logic                     pending;
    logic [VW-1:0]            snap;

    logic [VW-1:0]            live;
    logic [VW-1:0]            src;
    int                       nbytes;
    logic                     snap_sel;
    logic [7:0]               rd_byte;
    logic                     clr_all;

    assign addr    = bus.reg_address;
    assign rule    = bus.reg_address[3:0];
    assign bytecnt = bus.reg_bytecnt;
    assign byte0   = (bytecnt == '0);
    assign rule_ok = ({1'b0, rule} < NRULES);
    assign wr      = bus.reg_addrvalid && bus.reg_write;
    assign rd      = bus.reg_addrvalid && bus.reg_read;
    assign clr_all = wr && (kind == K_COMMIT) && byte0 && bus.write_data[1];

    // Decode the register number into a register kind; rule index is addr[3:0].
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        kind = K_NONE;
        if (addr[AW-1:4] == '0) begin
            case (addr[3:0])
                4'h0:    kind = K_REV;
                4'h1:    kind = K_ENABLE;
                4'h2:    kind = K_WIDTH;
                4'h3:    kind = K_TOGGLE;
                4'h4:    kind = K_COMMIT;
                4'h5:    kind = K_MPAT;
                4'h6:    kind = K_MBUF;
                4'h7:    kind = K_SYNC;
                4'h8:    kind = K_BLURB;
                4'h9:    kind = K_CLK;
                4'hA:    kind = K_RSYNC;
                default: kind = K_NONE;
            endcase
        end else if (rule_ok) begin
            if (addr[AW-1:4] == (AW-4)'(1))      kind = K_PAT;
            else if (addr[AW-1:4] == (AW-4)'(2)) kind = K_MASK;
            else if (addr[AW-1:4] == (AW-4)'(3)) kind = K_COUNT;
        end
    end

    // Read mux: live register value, its byte width, and whether it is snapshotted.
    always_comb begin
        live     = '0;
        nbytes   = 0;
        snap_sel = 1'b0;
        case (kind)
            K_REV:    begin live = VW'(8'h01);              nbytes = 1;         end
            K_ENABLE: begin live = VW'(O_pattern_enable);   nbytes = EN_BYTES;  end
            K_WIDTH:  begin live = VW'(O_trace_width);      nbytes = 1;         end
            K_TOGGLE: begin live = VW'(O_trig_toggle);      nbytes = 1;         end
            K_COMMIT: begin live = VW'(pending);            nbytes = 1;         end
            K_MPAT:   begin live = VW'(I_matching_pattern); nbytes = EN_BYTES;  snap_sel = 1'b1; end
            K_MBUF:   begin live = VW'(I_matching_buffer);  nbytes = BUF_BYTES; snap_sel = 1'b1; end
            K_SYNC:   begin live = VW'(I_synchronized);     nbytes = 1;         end
            K_BLURB:  begin live = VW'(I_last_blurb);       nbytes = BUF_BYTES; snap_sel = 1'b1; end
            K_CLK:    begin live = VW'(O_clksettings);      nbytes = 1;         end
            K_RSYNC:  begin live = VW'(O_trace_reset_sync); nbytes = 1;         end
            K_PAT: begin
                nbytes = BUF_BYTES;
                for (int r = 0; r < pMATCH_RULES; r++)
                    if (int'(rule) == r) live = VW'(stage_pat[r]);
            end
            K_MASK: begin
                nbytes = BUF_BYTES;
                for (int r = 0; r < pMATCH_RULES; r++)
                    if (int'(rule) == r) live = VW'(stage_mask[r]);
            end
            K_COUNT: begin
                nbytes   = CNT_BYTES;
                snap_sel = 1'b1;
                for (int r = 0; r < pMATCH_RULES; r++)
                    if (int'(rule) == r) live = VW'(cnt[r]);
            end
            default: ;
        endcase

        // Byte 0 always comes from the live value; later bytes of a
        // snapshotted register come from the copy taken at byte 0.
        src = (snap_sel && !byte0) ? snap : live;
        rd_byte = '0;
        for (int k = 0; k < VB; k++)
            if (int'(bytecnt) == k && k < nbytes) rd_byte = src[8*k +: 8];
    end

    // Registered read byte and snapshot capture on the byte-0 read.
    always_ff @(posedge usb_clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (reset_i) begin
            bus.read_data <= '0;
            snap          <= '0;
        end else begin
            bus.read_data <= rd ? rd_byte : 8'h00;
            if (rd && snap_sel && byte0) snap <= live;
        end
    end

    // Direct control registers, rule staging and atomic commit.
    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            O_clksettings      <= '0;
            O_pattern_enable   <= '0;
            O_trace_reset_sync <= 1'b0;
            O_trig_toggle      <= 1'b1;
            O_trace_width      <= 3'd4;
            O_commit           <= 1'b0;
            pending            <= 1'b0;
            // NOTE: the rule arrays are plain flops, not RAM, so they are reset;
            // this also discards a half-written staging burst.
            for (int r = 0; r < pMATCH_RULES; r++) begin
                stage_pat[r]  <= '0;
                stage_mask[r] <= '0;
                act_pat[r]    <= '0;
                act_mask[r]   <= '0;
            end
        end else begin
            O_commit <= 1'b0;
            if (wr) begin
                case (kind)
                    K_ENABLE:
                        for (int i = 0; i < pMATCH_RULES; i++)
                            if (int'(bytecnt) == i / 8) O_pattern_enable[i] <= bus.write_data[i % 8];
                    K_WIDTH:  if (byte0) O_trace_width      <= bus.write_data[2:0];
                    K_TOGGLE: if (byte0) O_trig_toggle      <= bus.write_data[0];
                    K_CLK:    if (byte0) O_clksettings      <= bus.write_data[4:0];
                    K_RSYNC:  if (byte0) O_trace_reset_sync <= bus.write_data[0];
                    K_COMMIT:
                        if (byte0 && bus.write_data[0]) begin
                            for (int r = 0; r < pMATCH_RULES; r++) begin
                                act_pat[r]  <= stage_pat[r];
                                act_mask[r] <= stage_mask[r];
                            end
                            O_commit <= 1'b1;
                            pending  <= 1'b0;
                        end
                    K_PAT: begin
                        pending <= 1'b1;
                        for (int r = 0; r < pMATCH_RULES; r++)
                            if (int'(rule) == r)
                                for (int i = 0; i < pBUFFER_SIZE; i++)
                                    if (int'(bytecnt) == i / 8) stage_pat[r][i] <= bus.write_data[i % 8];
                    end
                    K_MASK: begin
                        pending <= 1'b1;
                        for (int r = 0; r < pMATCH_RULES; r++)
                            if (int'(rule) == r)
                                for (int i = 0; i < pBUFFER_SIZE; i++)
                                    if (int'(bytecnt) == i / 8) stage_mask[r][i] <= bus.write_data[i % 8];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Saturating hit counters; any clear wins over a coincident hit.
    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            for (int r = 0; r < pMATCH_RULES; r++) cnt[r] <= '0;
        end else begin
            for (int r = 0; r < pMATCH_RULES; r++) begin
                if (clr_all || (wr && kind == K_COUNT && int'(rule) == r))
                    cnt[r] <= '0;
                else if (I_match_hit[r] && cnt[r] != '1)
                    cnt[r] <= cnt[r] + pCOUNT_WIDTH'(1);
            end
        end
    end

    // Flatten the active rules onto the trigger-facing buses.
    always_comb begin
        O_trace_pattern = '0;
        O_trace_mask    = '0;
        for (int r = 0; r < pMATCH_RULES; r++) begin
            O_trace_pattern[r*pBUFFER_SIZE +: pBUFFER_SIZE] = act_pat[r];
            O_trace_mask[r*pBUFFER_SIZE +: pBUFFER_SIZE]    = act_mask[r];
        end
    end
endmodule

// File: tb/tb_reg_trace_rules.sv
// Bench for reg_trace_rules: directed scenarios plus random traffic against a
// register-map model; read bytes go through a scoreboard queue checked by a
// monitor, while direct outputs are compared after every cycle.
module tb_reg_trace_rules;
    localparam int AW   = 21;
    localparam int BC   = 7;
    localparam int B    = 64;
    localparam int R    = 4;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic usb_clk = 1'b0;
    logic reset_i = 1'b1;
    always #5 usb_clk = ~usb_clk;

    reg_trace_rules_if #(.pADDR_WIDTH(AW), .pBYTECNT_SIZE(BC)) bus ();

    logic [R-1:0]   I_matching_pattern = '0;
    logic [B-1:0]   I_matching_buffer  = '0;
    logic [B-1:0]   I_last_blurb       = '0;
    logic           I_synchronized     = 1'b0;
    logic [R-1:0]   I_match_hit        = '0;
    logic [4:0]     O_clksettings;
    logic [R-1:0]   O_pattern_enable;
    logic           O_trace_reset_sync;
    logic           O_trig_toggle;
    logic [2:0]     O_trace_width;
    logic [R*B-1:0] O_trace_pattern;
    logic [R*B-1:0] O_trace_mask;
    logic           O_commit;

    reg_trace_rules #(
        .pADDR_WIDTH(AW), .pBYTECNT_SIZE(BC), .pBUFFER_SIZE(B),
        .pMATCH_RULES(R), .pCOUNT_WIDTH(CW)
    ) dut (
        .usb_clk(usb_clk), .reset_i(reset_i), .bus(bus.slave),
        .I_matching_pattern(I_matching_pattern), .I_matching_buffer(I_matching_buffer),
        .I_last_blurb(I_last_blurb), .I_synchronized(I_synchronized),
        .I_match_hit(I_match_hit), .O_clksettings(O_clksettings),
        .O_pattern_enable(O_pattern_enable), .O_trace_reset_sync(O_trace_reset_sync),
        .O_trig_toggle(O_trig_toggle), .O_trace_width(O_trace_width),
        .O_trace_pattern(O_trace_pattern), .O_trace_mask(O_trace_mask),
        .O_commit(O_commit)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0] exp;
        int         addr;
        int         bc;
    } rd_item_t;
    rd_item_t sb_q[$];
    rd_item_t mon_item;
    logic     rd_seen = 1'b0;
    logic     mon_en  = 1'b0;

    // Reference model of the register map.
    logic [R-1:0] m_en;
    logic [2:0]   m_width;
    logic         m_toggle;
    logic [4:0]   m_clk;
    logic         m_rsync;
    logic [B-1:0] m_spat [R];
    logic [B-1:0] m_smask[R];
    logic [B-1:0] m_apat [R];
    logic [B-1:0] m_amask[R];
    logic         m_pending;
    int           m_cnt  [R];
    logic [B-1:0] m_snap;
    logic         m_commit;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_en = '0; m_width = 3'd4; m_toggle = 1'b1; m_clk = '0; m_rsync = 1'b0;
        m_pending = 1'b0; m_snap = '0; m_commit = 1'b0;
        for (int r = 0; r < R; r++) begin
            m_spat[r] = '0; m_smask[r] = '0; m_apat[r] = '0; m_amask[r] = '0; m_cnt[r] = 0;
        end
    endtask

    // Value, byte width and snapshot behaviour of a register number.
    task automatic model_value(input int addr, output logic [B-1:0] val, output int n, output bit sn);
        val = '0; n = 0; sn = 1'b0;
        case (addr)
            0:  begin val = 64'h01;                     n = 1; end
            1:  begin val = B'(m_en);                   n = 1; end
            2:  begin val = B'(m_width);                n = 1; end
            3:  begin val = B'(m_toggle);               n = 1; end
            4:  begin val = B'(m_pending);              n = 1; end
            5:  begin val = B'(I_matching_pattern);     n = 1; sn = 1'b1; end
            6:  begin val = I_matching_buffer;          n = 8; sn = 1'b1; end
            7:  begin val = B'(I_synchronized);         n = 1; end
            8:  begin val = I_last_blurb;               n = 8; sn = 1'b1; end
            9:  begin val = B'(m_clk);                  n = 1; end
            10: begin val = B'(m_rsync);                n = 1; end
            default: begin
                if (addr >= 16 && addr < 16 + R)      begin val = m_spat[addr-16];  n = 8; end
                else if (addr >= 32 && addr < 32 + R) begin val = m_smask[addr-32]; n = 8; end
                else if (addr >= 48 && addr < 48 + R) begin val = B'(m_cnt[addr-48]); n = CW / 8; sn = 1'b1; end
            end
        endcase
    endtask

    task automatic model_write(input int addr, input int bc, input logic [7:0] d);
        logic [B-1:0] m;
        logic [15:0]  t;
        m = 64'hFF << (8 * bc);
        case (addr)
            1: if (bc < (R + 7) / 8) begin
                   t = 16'(m_en);
                   t = (t & ~m[15:0]) | (16'(d) << (8 * bc));
                   m_en = t[R-1:0];
               end
            2:  if (bc == 0) m_width  = d[2:0];
            3:  if (bc == 0) m_toggle = d[0];
            9:  if (bc == 0) m_clk    = d[4:0];
            10: if (bc == 0) m_rsync  = d[0];
            4: if (bc == 0) begin
                   if (d[0]) begin
                       for (int r = 0; r < R; r++) begin
                           m_apat[r] = m_spat[r]; m_amask[r] = m_smask[r];
                       end
                       m_pending = 1'b0;
                       m_commit  = 1'b1;
                   end
                   if (d[1]) for (int r = 0; r < R; r++) m_cnt[r] = 0;
               end
            default: begin
                if (addr >= 16 && addr < 16 + R) begin
                    m_pending = 1'b1;
                    if (bc < 8) m_spat[addr-16] = (m_spat[addr-16] & ~m) | (B'(d) << (8 * bc));
                end else if (addr >= 32 && addr < 32 + R) begin
                    m_pending = 1'b1;
                    if (bc < 8) m_smask[addr-32] = (m_smask[addr-32] & ~m) | (B'(d) << (8 * bc));
                end else if (addr >= 48 && addr < 48 + R) begin
                    m_cnt[addr-48] = 0;
                end
            end
        endcase
    endtask

    task automatic check_outputs();
        logic [R*B-1:0] ep, em;
        for (int r = 0; r < R; r++) begin
            ep[r*B +: B] = m_apat[r];
            em[r*B +: B] = m_amask[r];
        end
        check("O_pattern_enable",   O_pattern_enable,   m_en);
        check("O_trace_width",      O_trace_width,      m_width);
        check("O_trig_toggle",      O_trig_toggle,      m_toggle);
        check("O_clksettings",      O_clksettings,      m_clk);
        check("O_trace_reset_sync", O_trace_reset_sync, m_rsync);
        check("O_commit",           O_commit,           m_commit);
        check("O_trace_pattern",    O_trace_pattern,    ep);
        check("O_trace_mask",       O_trace_mask,       em);
    endtask

    // One bus cycle: optional read or write plus a hit vector.
    task automatic cycle(input bit do_wr, input bit do_rd, input int addr, input int bc,
                         input logic [7:0] d, input logic [R-1:0] hit);
        logic [B-1:0] val, tmp;
        int           n;
        bit           sn;
        rd_item_t     it;
        bus.reg_address   = (AW-BC)'(addr);
        bus.reg_bytecnt   = BC'(bc);
        bus.write_data    = d;
        bus.reg_write     = do_wr;
        bus.reg_read      = do_rd;
        bus.reg_addrvalid = do_wr | do_rd;
        I_match_hit       = hit;
        if (do_rd) begin
            model_value(addr, val, n, sn);
            tmp = (sn && bc != 0) ? m_snap : val;
            tmp = tmp >> (8 * bc);
            it.exp  = (bc < n) ? tmp[7:0] : 8'h00;
            it.addr = addr;
            it.bc   = bc;
            if (sn && bc == 0) m_snap = val;
            sb_q.push_back(it);
        end
        @(posedge usb_clk);
        #1;
        m_commit = 1'b0;
        for (int r = 0; r < R; r++)
            if (hit[r] && m_cnt[r] < CMAX) m_cnt[r]++;
        if (do_wr) model_write(addr, bc, d);
        bus.reg_write = 1'b0; bus.reg_read = 1'b0; bus.reg_addrvalid = 1'b0;
        I_match_hit = '0;
        check_outputs();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 0, 0, 8'h00, '0);
    endtask
    task automatic wr(input int addr, input int bc, input logic [7:0] d);
        cycle(1'b1, 1'b0, addr, bc, d, '0);
    endtask
    task automatic rd(input int addr, input int bc);
        cycle(1'b0, 1'b1, addr, bc, 8'h00, '0);
    endtask
    task automatic pulse_reset(input int n);
        reset_i = 1'b1;
        repeat (n) @(posedge usb_clk);
        #1;
        reset_i = 1'b0;
        model_reset();
        check_outputs();
    endtask

    // Read-data monitor: a read strobe sampled on one edge yields a byte after it.
    always @(posedge usb_clk) rd_seen <= bus.reg_read && bus.reg_addrvalid && !reset_i;

    always @(negedge usb_clk) begin
        if (mon_en) begin
            if (rd_seen) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL read_data: byte %0h presented with no read outstanding", bus.read_data);
                end else begin
                    mon_item = sb_q.pop_front();
                    check($sformatf("read_data a=%0h b=%0d", mon_item.addr, mon_item.bc),
                          bus.read_data, mon_item.exp);
                end
            end else begin
                check("read_data_idle", bus.read_data, 8'h00);
            end
        end
    end

    int addr_pool[] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 15, 16, 17, 18, 19, 20,
                        32, 33, 34, 35, 36, 48, 49, 50, 51, 52, 63, 256};
    int mapped[]    = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 16, 17, 18, 19,
                        32, 33, 34, 35, 48, 49, 50, 51};

    initial begin
        bus.reg_address = '0; bus.reg_bytecnt = '0; bus.write_data = '0;
        bus.reg_read = 1'b0; bus.reg_write = 1'b0; bus.reg_addrvalid = 1'b0;
        model_reset();

        // Reset state and every mapped register.
        pulse_reset(3);
        mon_en = 1'b1;
        foreach (mapped[i]) rd(mapped[i], 0);

        // Stage rule 2 pattern without committing.
        for (int k = 0; k < 8; k++) wr(18, k, 8'(8'h11 * (k + 1)));
        for (int k = 0; k < 8; k++) rd(18, k);
        rd(4, 0);
        check("rule2_before_commit", O_trace_pattern[2*B +: B], 64'h0);
        wr(4, 0, 8'h01);
        check("commit_pulse_high", O_commit, 1'b1);
        check("rule2_after_commit", O_trace_pattern[2*B +: B], 64'h8877665544332211);
        idle(1);
        check("commit_pulse_low", O_commit, 1'b0);
        rd(4, 0);

        // Hit counting and saturation.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 0, 0, 8'h00, 4'b0010);
            idle(1);
        end
        rd(49, 0); rd(49, 1);
        repeat (300) cycle(1'b0, 1'b0, 0, 0, 8'h00, 4'b0001);
        rd(48, 0);

        // Clear coincident with a hit, then global clear.
        repeat (3) cycle(1'b0, 1'b0, 0, 0, 8'h00, 4'b1000);
        rd(51, 0);
        cycle(1'b1, 1'b0, 51, 0, 8'h5A, 4'b1000);
        rd(51, 0);
        wr(4, 0, 8'h02);
        for (int r = 0; r < R; r++) rd(48 + r, 0);

        // Snapshot coherence.
        I_last_blurb = 64'hA;
        rd(8, 0);
        I_last_blurb = 64'hB;
        for (int k = 1; k < 8; k++) rd(8, k);
        I_last_blurb = 64'h1122334455667788;
        rd(8, 0);
        I_last_blurb = 64'hFFEEDDCCBBAA9988;
        for (int k = 1; k < 8; k++) rd(8, k);
        rd(8, 0);

        // Unmapped rule slots.
        wr(20, 0, 8'hFF); wr(36, 0, 8'hFF); wr(52, 0, 8'hFF);
        rd(20, 0); rd(36, 0); rd(52, 0); rd(4, 0);

        // Reset in the middle of a staging burst.
        wr(16, 0, 8'hDE); wr(16, 1, 8'hAD); wr(2, 0, 8'h07);
        pulse_reset(1);
        rd(16, 0); rd(16, 1); rd(4, 0); rd(2, 0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            int op, a, bc;
            logic [R-1:0] h;
            I_matching_pattern = R'($urandom);
            I_matching_buffer  = {$urandom, $urandom};
            I_last_blurb       = {$urandom, $urandom};
            I_synchronized     = 1'($urandom);
            op = int'($urandom_range(0, 9));
            a  = addr_pool[$urandom_range(0, addr_pool.size() - 1)];
            bc = int'($urandom_range(0, 9));
            h  = ($urandom_range(0, 2) == 0) ? R'($urandom) : '0;
            if (op < 4)      cycle(1'b0, 1'b1, a, bc, 8'h00, h);
            else if (op < 7) cycle(1'b1, 1'b0, a, bc, 8'($urandom), h);
            else             cycle(1'b0, 1'b0, 0, 0, 8'h00, h);
        end

        idle(3);
        check("scoreboard_drained", 256'(sb_q.size()), 256'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
